// File: rtl/reg_file_mp_if.sv
// Decode/writeback bus of the multi-port register file.
// Write ports D and D2, read ports A and B, and the alloc request.
interface reg_file_mp_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              i_en;
    logic              i_we;
    logic [ADDR_W-1:0] i_selD;
    logic [DATA_W-1:0] i_dataD;
    logic              i_we2;
    logic [ADDR_W-1:0] i_selD2;
    logic [DATA_W-1:0] i_dataD2;
    logic [ADDR_W-1:0] i_selA;
    logic [ADDR_W-1:0] i_selB;
    logic              i_alloc;
    logic [ADDR_W-1:0] i_selAlloc;
    logic [DATA_W-1:0] o_dataA;
    logic [DATA_W-1:0] o_dataB;
    logic              o_rdyA;
    logic              o_rdyB;

    modport master (
        output i_en, i_we, i_selD, i_dataD,
        output i_we2, i_selD2, i_dataD2,
        output i_selA, i_selB, i_alloc, i_selAlloc,
        input  o_dataA, o_dataB, o_rdyA, o_rdyB
    );

    modport slave (
        input  i_en, i_we, i_selD, i_dataD,
        input  i_we2, i_selD2, i_dataD2,
        input  i_selA, i_selB, i_alloc, i_selAlloc,
        output o_dataA, o_dataB, o_rdyA, o_rdyB
    );
endinterface

// File: rtl/reg_file_mp.sv
// Two-read/two-write register file with optional bypass, optional zero r0,
// and a pending-write scoreboard driving registered ready flags.
module reg_file_mp #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input logic         i_clk,
    input logic         i_rst,
    reg_file_mp_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [DEPTH-1:0]             pend_q, pend_d;
    logic [DATA_W-1:0]            data_a_q, data_a_d;
    logic [DATA_W-1:0]            data_b_q, data_b_d;
    logic                         rdy_a_q, rdy_a_d;
    logic                         rdy_b_q, rdy_b_d;

    function automatic logic is_r0(input logic [ADDR_W-1:0] sel);
        return (ZERO_R0 != 0) && (sel == '0);
    endfunction

    always_comb begin
        regs_d   = regs_q;
        pend_d   = pend_q;
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        rdy_a_d  = rdy_a_q;
        rdy_b_d  = rdy_b_q;
        if (bus.i_en) begin
            // D2 applied first so port D overrides it on an address clash
            if (bus.i_we2 && !is_r0(bus.i_selD2))
                regs_d[bus.i_selD2] = bus.i_dataD2;
            if (bus.i_we && !is_r0(bus.i_selD))
                regs_d[bus.i_selD] = bus.i_dataD;
            if (bus.i_we2)
                pend_d[bus.i_selD2] = 1'b0;
            if (bus.i_we)
                pend_d[bus.i_selD] = 1'b0;
            if (bus.i_alloc)
                pend_d[bus.i_selAlloc] = 1'b1;
            if (ZERO_R0 != 0)
                pend_d[0] = 1'b0;

            // regs_d already carries same-edge writes, so it is the bypass view
            if (is_r0(bus.i_selA))
                data_a_d = '0;
            else if (BYPASS != 0)
                data_a_d = regs_d[bus.i_selA];
            else
                data_a_d = regs_q[bus.i_selA];

            if (is_r0(bus.i_selB))
                data_b_d = '0;
            else if (BYPASS != 0)
                data_b_d = regs_d[bus.i_selB];
            else
                data_b_d = regs_q[bus.i_selB];

            rdy_a_d = ~pend_d[bus.i_selA];
            rdy_b_d = ~pend_d[bus.i_selB];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            regs_q   <= '0;
            pend_q   <= '0;
            data_a_q <= '0;
            data_b_q <= '0;
            rdy_a_q  <= 1'b1;
            rdy_b_q  <= 1'b1;
        end else begin
            regs_q   <= regs_d;
            pend_q   <= pend_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            rdy_a_q  <= rdy_a_d;
            rdy_b_q  <= rdy_b_d;
        end
    end

    assign bus.o_dataA = data_a_q;
    assign bus.o_dataB = data_b_q;
    assign bus.o_rdyA  = rdy_a_q;
    assign bus.o_rdyB  = rdy_b_q;
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised next-generation register file for the 16-bit RISC core.
- Two registered read ports and two write ports: D is the writeback port, D2 the late or load-return port.
- Optional write-to-read bypass, optional hardwired-zero r0, and a per-register pending-write scoreboard that gives the decode stage a hazard/ready indication.
- Sits between decode (read/alloc) and writeback (write); drop-in superset of the existing 8x16 file.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 3, select width; DEPTH = 2**ADDR_W registers.
- BYPASS, 1, 1 = same-edge write data forwarded to read outputs; 0 = read returns pre-write contents.
- ZERO_R0, 0, 1 = register 0 reads 0, ignores writes, is never pending.

Ports:
- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  synchronous reset, active-high
- i_en  in  1  global enable; 0 freezes all state and outputs
- i_we  in  1  write enable, port D
- i_selD  in  ADDR_W  write address, port D
- i_dataD  in  DATA_W  write data, port D
- i_we2  in  1  write enable, port D2
- i_selD2  in  ADDR_W  write address, port D2
- i_dataD2  in  DATA_W  write data, port D2
- i_selA  in  ADDR_W  read address, port A
- i_selB  in  ADDR_W  read address, port B
- i_alloc  in  1  mark register i_selAlloc pending (instruction issued with that destination)
- i_selAlloc  in  ADDR_W  register to mark pending
- o_dataA  out  DATA_W  registered read data, port A
- o_dataB  out  DATA_W  registered read data, port B
- o_rdyA  out  1  registered: register at i_selA not pending
- o_rdyB  out  1  registered: register at i_selB not pending

Behaviour:
- Reset (i_rst=1 at edge) dominates i_en and all other inputs.
  - All registers 0, all pending bits 0.
  - o_dataA = o_dataB = 0; o_rdyA = o_rdyB = 1.
  - Reset mid-sequence discards any same-edge writes and allocs.
- i_en=0: no register write, no pending update, outputs hold previous values.
- Write (i_en=1): on the edge, i_we writes i_dataD to reg[i_selD]; i_we2 writes i_dataD2 to reg[i_selD2].
  - Both ports writing the same address: port D wins; D2 data is dropped.
- Read: 1-cycle latency. On an enabled edge, o_dataA is loaded from the address on i_selA (o_dataB likewise from i_selB).
  - BYPASS=1: if i_we and i_selD==i_selA, load i_dataD; else if i_we2 and i_selD2==i_selA, load i_dataD2; else load reg[i_selA].
  - BYPASS=0: always load the pre-edge reg[i_selA].
  - Same rules for port B.
- ZERO_R0=1:
  - Writes to address 0 are ignored.
  - Reads of address 0 return 0, with bypass suppressed.
  - Alloc to address 0 is ignored; its rdy is always 1.
- Scoreboard, pending[DEPTH] (i_en=1):
  - Set pending[i_selAlloc] on i_alloc.
  - Clear pending[i_selD] on i_we and pending[i_selD2] on i_we2.
  - Alloc and write to the same register on one edge: alloc wins (pending stays/becomes 1).
- Ready outputs: on an enabled edge, o_rdyA <= ~pending_next[i_selA], where pending_next is the post-edge scoreboard.
  - This gives a one-cycle view consistent with o_dataA.
- No arithmetic; addresses never wrap beyond DEPTH (full decode).

Test Plan:
1. Reset, then en=1, we=1, selD=0, dataD=16'hFFFF, selA=0, selB=1 (BYPASS=1) -> after the edge o_dataA=16'hFFFF, o_dataB=0; next cycle with we=0, o_dataA stays 16'hFFFF.
2. BYPASS=0: write 16'h2222 to r2 while selA=2 -> first edge o_dataA=0 (old value), second edge o_dataA=16'h2222.
3. Same edge we=1/selD=4/dataD=16'h4444 and we2=1/selD2=4/dataD2=16'h5555 -> r4=16'h4444; with selA=4 and BYPASS=1, o_dataA=16'h4444 on that edge.
4. alloc r3 -> o_rdyA=0 (selA=3); we2 writes r3=16'h3333 -> o_rdyA=1, o_dataA=16'h3333; alloc and we to r3 on the same edge -> o_rdyA=0.
5. ZERO_R0=1: we=1, selD=0, dataD=16'hABCD, alloc r0, selA=0 -> o_dataA=0, o_rdyA=1.
6. en=0 with we/alloc asserted -> no change in registers, scoreboard or outputs; then i_rst=1 with we=1 -> all registers 0, o_data*=0, o_rdy*=1.
